// File: rtl/run_ctrl.sv
// Run-control FSM for the 16-bit core: exec/idle state, HALT capture,
// single-step, pipeline restart pulse and instruction-memory sharing.
module run_ctrl #(
   parameter int         ADDR_W  = 8,
   parameter int         DATA_W  = 16,
   parameter int         CNT_W   = 16,
   parameter logic [4:0] HALT_OP = 5'h1F
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              step,
   input  logic              restart,
   input  logic [DATA_W-1:0] wb_ir,
   input  logic [ADDR_W-1:0] pc_addr,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic              state,
   output logic              cpu_rst_n,
   output logic              halted,
   output logic              ld_gnt,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_we,
   output logic [CNT_W-1:0]  cyc_cnt
);

   localparam logic EXEC_ST = 1'b1;
   localparam logic IDLE_ST = 1'b0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_STEP,
      S_HALTED,
      S_LOAD
   } fsm_e;

   fsm_e             fsm_q, fsm_d;
   logic             state_q, state_d;
   logic             halted_q, halted_d;
   logic             gnt_q, gnt_d;
   logic             rstn_q, rstn_d;
   logic             arm_q, arm_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             halt_hit;
   logic             unused_ir;

   assign halt_hit  = (wb_ir[DATA_W-1 -: 5] == HALT_OP);
   assign unused_ir = ^wb_ir[DATA_W-6:0];

   always_comb begin
      fsm_d    = fsm_q;
      halted_d = halted_q;
      rstn_d   = 1'b1;
      arm_d    = arm_q;
      cnt_d    = cnt_q;
      if (state_q == EXEC_ST && cnt_q != '1) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      unique case (fsm_q)
         S_IDLE: begin
            // a held step only fires again after being seen low here
            if (!step) arm_d = 1'b1;
            if (restart) begin
               rstn_d = 1'b0;
               cnt_d  = '0;
            end else if (ld_req) begin
               fsm_d = S_LOAD;
            end else if (step && arm_q) begin
               fsm_d = S_STEP;
               arm_d = 1'b0;
            end else if (start) begin
               fsm_d = S_RUN;
            end
         end
         S_RUN: begin
            if (halt_hit) begin
               fsm_d    = S_HALTED;
               halted_d = 1'b1;
            end else if (stop) begin
               fsm_d = S_IDLE;
            end
         end
         S_STEP: begin
            if (halt_hit) begin
               fsm_d    = S_HALTED;
               halted_d = 1'b1;
            end else begin
               fsm_d = S_IDLE;
            end
         end
         S_HALTED: begin
            if (restart) begin
               fsm_d    = S_IDLE;
               halted_d = 1'b0;
               rstn_d   = 1'b0;
               cnt_d    = '0;
            end else if (ld_req) begin
               fsm_d = S_LOAD;
            end
         end
         S_LOAD: begin
            // halted_q remembers where the loader came from
            if (!ld_req) fsm_d = halted_q ? S_HALTED : S_IDLE;
         end
         default: fsm_d = S_IDLE;
      endcase
      state_d = (fsm_d == S_RUN || fsm_d == S_STEP) ? EXEC_ST : IDLE_ST;
      gnt_d   = (fsm_d == S_LOAD);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fsm_q    <= S_IDLE;
         state_q  <= IDLE_ST;
         halted_q <= 1'b0;
         gnt_q    <= 1'b0;
         rstn_q   <= 1'b0;
         arm_q    <= 1'b1;
         cnt_q    <= '0;
      end else begin
         fsm_q    <= fsm_d;
         state_q  <= state_d;
         halted_q <= halted_d;
         gnt_q    <= gnt_d;
         rstn_q   <= rstn_d;
         arm_q    <= arm_d;
         cnt_q    <= cnt_d;
      end
   end

   assign state     = state_q;
   assign halted    = halted_q;
   assign ld_gnt    = gnt_q;
   assign cpu_rst_n = rstn_q;
   assign cyc_cnt   = cnt_q;
   assign imem_addr = gnt_q ? ld_addr : pc_addr;
   assign imem_we   = gnt_q & ld_we;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: flag-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_run_ctrl;

   localparam logic [4:0] HALT = 5'h1F;

   logic        clock = 1'b0;
   logic        reset, start, stop, step, restart;
   logic [15:0] wb_ir;
   logic [7:0]  pc_addr, ld_addr;
   logic        ld_req, ld_we;
   logic        state, cpu_rst_n, halted, ld_gnt, imem_we;
   logic [7:0]  imem_addr;
   logic [15:0] cyc_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   // model: independent flags rather than a state number
   bit          m_run, m_step, m_halt, m_load, m_armed, m_rstn;
   logic [15:0] m_cnt;

   run_ctrl dut (
      .clock(clock), .reset(reset), .start(start), .stop(stop),
      .step(step), .restart(restart), .wb_ir(wb_ir),
      .pc_addr(pc_addr), .ld_req(ld_req), .ld_we(ld_we),
      .ld_addr(ld_addr), .state(state), .cpu_rst_n(cpu_rst_n),
      .halted(halted), .ld_gnt(ld_gnt), .imem_addr(imem_addr),
      .imem_we(imem_we), .cyc_cnt(cyc_cnt)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_edge();
      bit exec_now;
      bit halt_seen;
      exec_now  = m_run || m_step;
      halt_seen = (wb_ir[15:11] == HALT);
      if (reset) begin
         m_run = 0; m_step = 0; m_halt = 0; m_load = 0;
         m_armed = 1; m_rstn = 0; m_cnt = 16'h0;
      end else begin
         m_rstn = 1;
         if (exec_now && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
         if (m_step) begin
            m_step = 0;
            if (halt_seen) m_halt = 1;
         end else if (m_run) begin
            if (halt_seen) begin
               m_run = 0; m_halt = 1;
            end else if (stop) begin
               m_run = 0;
            end
         end else if (m_load) begin
            if (!ld_req) m_load = 0;
         end else if (m_halt) begin
            if (restart) begin
               m_halt = 0; m_rstn = 0; m_cnt = 16'h0;
            end else if (ld_req) begin
               m_load = 1;
            end
         end else begin
            if (restart) begin
               m_rstn = 0; m_cnt = 16'h0;
            end else if (ld_req) begin
               m_load = 1;
            end else if (step && m_armed) begin
               m_step = 1; m_armed = 0;
            end else if (start) begin
               m_run = 1;
            end
            if (!step) m_armed = 1;
         end
      end
   endtask

   always @(posedge clock) begin
      model_edge();
      #1;
      check("m_state", {31'h0, state}, {31'h0, m_run | m_step});
      check("m_halted", {31'h0, halted}, {31'h0, m_halt});
      check("m_gnt", {31'h0, ld_gnt}, {31'h0, m_load});
      check("m_rstn", {31'h0, cpu_rst_n}, {31'h0, m_rstn});
      check("m_cnt", {16'h0, cyc_cnt}, {16'h0, m_cnt});
      check("m_addr", {24'h0, imem_addr},
            {24'h0, m_load ? ld_addr : pc_addr});
      check("m_we", {31'h0, imem_we}, {31'h0, m_load & ld_we});
   end

   initial begin
      reset = 1; start = 0; stop = 0; step = 0; restart = 0;
      wb_ir = 16'h0; pc_addr = 8'h55; ld_req = 0; ld_we = 0;
      ld_addr = 8'h0;
      repeat (2) @(negedge clock);
      reset = 0;
      check("rst_state", {31'h0, state}, 0);
      check("rst_rstn", {31'h0, cpu_rst_n}, 0);
      check("rst_cnt", {16'h0, cyc_cnt}, 0);
      check("rst_halted", {31'h0, halted}, 0);
      check("rst_gnt", {31'h0, ld_gnt}, 0);
      @(negedge clock);
      check("rstn_rise", {31'h0, cpu_rst_n}, 1);

      start = 1;
      @(negedge clock) start = 0;
      check("run_state", {31'h0, state}, 1);
      repeat (9) @(negedge clock);
      stop = 1;
      @(negedge clock) stop = 0;
      check("stop_state", {31'h0, state}, 0);
      check("stop_cnt", {16'h0, cyc_cnt}, 10);

      restart = 1;
      @(negedge clock) restart = 0;
      check("rs_rstn", {31'h0, cpu_rst_n}, 0);
      check("rs_cnt", {16'h0, cyc_cnt}, 0);

      step = 1;
      repeat (5) @(negedge clock);
      step = 0;
      check("step_cnt1", {16'h0, cyc_cnt}, 1);
      @(negedge clock) step = 1;
      @(negedge clock) step = 0;
      @(negedge clock);
      check("step_cnt2", {16'h0, cyc_cnt}, 2);

      start = 1;
      @(negedge clock) start = 0;
      @(negedge clock);
      wb_ir = {HALT, 11'h0}; stop = 1;
      @(negedge clock) begin wb_ir = 16'h0; stop = 0; end
      check("halt_flag", {31'h0, halted}, 1);
      check("halt_state", {31'h0, state}, 0);
      start = 1; step = 1;
      @(negedge clock) begin start = 0; step = 0; end
      check("halt_hold", {31'h0, halted}, 1);
      check("halt_nostart", {31'h0, state}, 0);
      ld_req = 1;
      @(negedge clock);
      check("hload_gnt", {31'h0, ld_gnt}, 1);
      check("hload_halted", {31'h0, halted}, 1);
      ld_req = 0;
      @(negedge clock);
      check("hload_back", {31'h0, halted}, 1);
      restart = 1;
      @(negedge clock) restart = 0;
      check("hrs_rstn", {31'h0, cpu_rst_n}, 0);
      check("hrs_cnt", {16'h0, cyc_cnt}, 0);
      check("hrs_halted", {31'h0, halted}, 0);
      @(negedge clock);
      check("hrs_rise", {31'h0, cpu_rst_n}, 1);

      ld_req = 1;
      @(negedge clock);
      check("ld_gnt", {31'h0, ld_gnt}, 1);
      for (int i = 0; i < 4; i++) begin
         ld_we = 1; ld_addr = 8'(i);
         #1;
         check("ld_we", {31'h0, imem_we}, 1);
         check("ld_addr", {24'h0, imem_addr}, i);
         @(negedge clock);
      end
      ld_we = 0; ld_req = 0;
      @(negedge clock);
      check("ld_drop", {31'h0, ld_gnt}, 0);
      check("ld_pc", {24'h0, imem_addr}, 32'h55);

      start = 1;
      @(negedge clock) start = 0;
      ld_req = 1; ld_we = 1; ld_addr = 8'h07;
      @(negedge clock);
      check("run_nogrant", {31'h0, ld_gnt}, 0);
      check("run_nowe", {31'h0, imem_we}, 0);
      restart = 1;
      @(negedge clock) restart = 0;
      check("run_rs_state", {31'h0, state}, 1);
      check("run_rs_rstn", {31'h0, cpu_rst_n}, 1);
      ld_req = 0; ld_we = 0; stop = 1;
      @(negedge clock) stop = 0;
      check("run2_stop", {31'h0, state}, 0);

      force dut.cnt_q = 16'hFFFE;
      m_cnt = 16'hFFFE;
      @(negedge clock) release dut.cnt_q;
      check("sat_pre", {16'h0, cyc_cnt}, 32'hFFFE);
      start = 1;
      @(negedge clock) start = 0;
      repeat (3) @(negedge clock);
      check("sat_cnt", {16'h0, cyc_cnt}, 32'hFFFF);
      check("sat_run", {31'h0, state}, 1);
      reset = 1;
      @(negedge clock);
      check("mid_state", {31'h0, state}, 0);
      check("mid_cnt", {16'h0, cyc_cnt}, 0);
      check("mid_rstn", {31'h0, cpu_rst_n}, 0);
      check("mid_halted", {31'h0, halted}, 0);
      check("mid_gnt", {31'h0, ld_gnt}, 0);
      reset = 0;
      repeat (2) @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
